// File: rtl/move_input_conditioner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : move_input_conditioner                                    |
// | Purpose : Synchronizes and debounces four raw push-buttons and      |
// |           turns each press into one move request that is held       |
// |           until the game FSM accepts it with ready.                 |
// | Option  : define AUTO_REPEAT_EN to re-issue a held direction after  |
// |           REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.     |
// | Revision: 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module move_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnU,
  input  logic BtnD,
  input  logic BtnL,
  input  logic BtnR,
  input  logic ready,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic busy
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEND = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right.
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_deb;
  logic [3:0] w_pick;
  logic [3:0] r_dir;
  logic [3:0] r_move;
  logic       r_busy;
  state_t     r_state;

  assign w_raw = {BtnU, BtnD, BtnL, BtnR};

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
    logic              r_level;
    logic [c_DB_W-1:0] r_cnt;

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
        r_level <= 1'b0;
        r_cnt   <= '0;
      end else if (r_sync2[gi] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == c_DB_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_deb[gi] = r_level;
  end

  // Fixed priority up > down > left > right, one-hot result.
  always_comb begin
    w_pick = 4'b0000;
    if (w_deb[3])      w_pick = 4'b1000;
    else if (w_deb[2]) w_pick = 4'b0100;
    else if (w_deb[1]) w_pick = 4'b0010;
    else if (w_deb[0]) w_pick = 4'b0001;
  end

`ifdef AUTO_REPEAT_EN
  localparam int c_REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_REP_W   = $clog2(c_REP_MAX) + 1;
  localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
  localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

  logic [c_REP_W-1:0] r_rep_cnt;
  logic               r_rep_off;   // latched button was released: no more repeats this press
  logic               r_rep_done;  // first repeat already issued: use the period
  logic [c_REP_W-1:0] w_rep_last;

  assign w_rep_last = r_rep_done ? c_PERIOD_LAST : c_DELAY_LAST;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

  // Request FSM: latch a direction, hold it until accepted, then wait for release.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_dir   <= 4'b0;
      r_move  <= 4'b0;
      r_busy  <= 1'b0;
`ifdef AUTO_REPEAT_EN
      r_rep_cnt  <= '0;
      r_rep_off  <= 1'b0;
      r_rep_done <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|w_deb) begin
            r_dir   <= w_pick;
            r_move  <= w_pick;
            r_busy  <= 1'b1;
            r_state <= S_PEND;
          end
        end
        S_PEND: begin
          if (ready) begin
            r_move  <= 4'b0;
            r_state <= S_HOLD;
`ifdef AUTO_REPEAT_EN
            r_rep_cnt <= '0;
`endif
          end
        end
        S_HOLD: begin
          if (w_deb == 4'b0) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
`ifdef AUTO_REPEAT_EN
            r_rep_off  <= 1'b0;
            r_rep_done <= 1'b0;
          end else if (!r_rep_off) begin
            if ((w_deb & r_dir) == 4'b0) begin
              r_rep_off <= 1'b1;
            end else if (r_rep_cnt == w_rep_last) begin
              r_move     <= r_dir;
              r_rep_done <= 1'b1;
              r_rep_cnt  <= '0;
              r_state    <= S_PEND;
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
`endif
          end
        end
        default: begin
          r_move  <= 4'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign up    = r_move[3];
  assign down  = r_move[2];
  assign left  = r_move[1];
  assign right = r_move[0];
  assign busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_move_input_conditioner.sv
`default_nettype none
// Testbench for move_input_conditioner: directed scenarios plus random
// button/ready/reset traffic, checked every cycle against a behavioural model.
module tb_move_input_conditioner;

  localparam int DB  = 4;
  localparam int RD  = 20;
  localparam int RP  = 8;

  logic       Clk;
  logic       Reset;
  logic       ready;
  logic [3:0] btn;   // [3]=U [2]=D [1]=L [0]=R
  logic       up, down, left, right, busy;
  logic [3:0] outs;

  assign outs = {up, down, left, right};

  move_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .BtnU (btn[3]),
    .BtnD (btn[2]),
    .BtnL (btn[1]),
    .BtnR (btn[0]),
    .ready(ready),
    .up   (up),
    .down (down),
    .left (left),
    .right(right),
    .busy (busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0] m_hist[$];     // raw samples, newest first
  bit [3:0] m_used[$];     // samples the debouncer acts on, newest first
  bit [3:0] m_deb;
  int       m_last_flip[4];
  int       m_cyc = 0;
  bit       m_pend, m_wait;
  int       m_dir;         // 0=up 1=down 2=left 3=right
  bit       m_rep_off, m_rep_done;
  int       m_hold_t;
  bit [3:0] exp_move;
  bit       exp_busy;

  initial begin
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        m_hist.delete();
        m_used.delete();
        m_deb = 4'b0;
        for (int b = 0; b < 4; b++) m_last_flip[b] = -1000;
        m_pend = 0; m_wait = 0; m_dir = 0;
        m_rep_off = 0; m_rep_done = 0; m_hold_t = 0;
        exp_move = 4'b0; exp_busy = 0;
      end else begin
        bit [3:0] used;
        bit [3:0] old_deb;
        bit       all_diff;
        m_cyc++;
        old_deb = m_deb;
        // request handling uses the levels debounced before this edge
        if (m_pend) begin
          if (ready) begin
            m_pend = 0; m_wait = 1; m_hold_t = 0;
          end
        end else if (m_wait) begin
          if (old_deb == 4'b0) begin
            m_wait = 0; m_rep_off = 0; m_rep_done = 0;
          end
`ifdef AUTO_REPEAT_EN
          else if (!m_rep_off) begin
            if (!old_deb[3-m_dir]) m_rep_off = 1;
            else begin
              m_hold_t++;
              if (m_hold_t == (m_rep_done ? RP : RD)) begin
                m_pend = 1; m_wait = 0; m_rep_done = 1;
              end
            end
          end
`endif
        end else if (old_deb != 4'b0) begin
          if (old_deb[3])      m_dir = 0;
          else if (old_deb[2]) m_dir = 1;
          else if (old_deb[1]) m_dir = 2;
          else                 m_dir = 3;
          m_pend = 1;
        end
        // debounce: the sample seen now is the raw value from two edges ago
        used = (m_hist.size() >= 2) ? m_hist[1] : 4'b0;
        m_hist.push_front(btn);
        if (m_hist.size() > 2) void'(m_hist.pop_back());
        m_used.push_front(used);
        if (m_used.size() > DB) void'(m_used.pop_back());
        for (int b = 0; b < 4; b++) begin
          if (m_used.size() == DB && (m_cyc - m_last_flip[b]) >= DB) begin
            all_diff = 1;
            foreach (m_used[j]) if (m_used[j][b] == m_deb[b]) all_diff = 0;
            if (all_diff) begin
              m_deb[b] = ~m_deb[b];
              m_last_flip[b] = m_cyc;
            end
          end
        end
        exp_move = m_pend ? (4'b1000 >> m_dir) : 4'b0;
        exp_busy = m_pend | m_wait;
      end
    end
  end

  // ---------------- per-cycle compare and transfer log ----------------
  int xfer_q[$];
  bit seen_out;

  initial begin
    forever begin
      @(negedge Clk);
      check("moves", {28'b0, outs}, {28'b0, exp_move});
      check("busy", {31'b0, busy}, {31'b0, exp_busy});
      if ((outs != 4'b0) && ready && !Reset) xfer_q.push_back(m_cyc + 1);
      if (outs != 4'b0) seen_out = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int kind, b, tot;
    Reset = 1'b1; ready = 1'b1; btn = 4'b0; seen_out = 0;
    step(3);
    check("reset_outs", {28'b0, outs}, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    Reset = 1'b0;
    step(5);

    // clean up press, ready=1
    btn = 4'b1000;
    step(6);
    check("up_edge6", {28'b0, outs}, 32'h0);
    step(1);
    check("up_edge7", {28'b0, outs}, 32'h8);
    check("model_up_edge7", {28'b0, exp_move}, 32'h8);
    check("busy_edge7", {31'b0, busy}, 32'h1);
    step(1);
    check("up_edge8", {28'b0, outs}, 32'h0);
    check("busy_edge8", {31'b0, busy}, 32'h1);
    step(4);
    btn = 4'b0;
    step(6);
    check("busy_release6", {31'b0, busy}, 32'h1);
    step(1);
    check("busy_release7", {31'b0, busy}, 32'h0);
    check("model_busy_release7", {31'b0, exp_busy}, 32'h0);
    step(10);

    // bouncing left: short pulses only
    seen_out = 0;
    tot = 0;
    while (tot < 30) begin
      b = $urandom_range(1, 3);
      btn[1] = ~btn[1];
      step(b);
      tot += b;
    end
    btn = 4'b0;
    step(12);
    check("bounce_no_output", {31'b0, seen_out}, 32'h0);

    // right and down together: down wins
    btn = 4'b0101;
    step(7);
    check("prio_down", {28'b0, outs}, 32'h4);
    step(1);
    check("prio_accepted", {28'b0, outs}, 32'h0);
    step(20);
    btn = 4'b0;
    step(20);
    btn = 4'b0001;
    step(7);
    check("right_alone", {28'b0, outs}, 32'h1);
    step(2);
    btn = 4'b0;
    step(15);

    // down held while consumer not ready
    xfer_q.delete();
    ready = 1'b0;
    btn = 4'b0100;
    step(7);
    check("wait_down_rise", {28'b0, outs}, 32'h4);
    step(10);
    check("wait_down_held", {28'b0, outs}, 32'h4);
    ready = 1'b1;
    step(1);
    check("wait_down_drop", {28'b0, outs}, 32'h0);
    btn = 4'b0;
    step(12);
    check("wait_one_xfer", xfer_q.size(), 32'd1);

    // reset while left pending, left still held
    ready = 1'b0;
    btn = 4'b0010;
    step(7);
    check("pend_left", {28'b0, outs}, 32'h2);
    Reset = 1'b1;
    #1;
    check("reset_drop_outs", {28'b0, outs}, 32'h0);
    check("reset_drop_busy", {31'b0, busy}, 32'h0);
    step(1);
    Reset = 1'b0;
    step(6);
    check("left_after_rst6", {28'b0, outs}, 32'h0);
    step(1);
    check("left_after_rst7", {28'b0, outs}, 32'h2);
    ready = 1'b1;
    step(1);
    btn = 4'b0;
    step(15);

    // long hold of up, ready=1
    xfer_q.delete();
    btn = 4'b1000;
    step(60);
    btn = 4'b0;
    step(20);
`ifdef AUTO_REPEAT_EN
    check("repeat_count_ge4", {31'b0, xfer_q.size() >= 4}, 32'h1);
    if (xfer_q.size() >= 4) begin
      check("repeat_gap1", xfer_q[1] - xfer_q[0], 32'd21);
      check("repeat_gap2", xfer_q[2] - xfer_q[1], 32'd9);
      check("repeat_gap3", xfer_q[3] - xfer_q[2], 32'd9);
    end
`else
    check("hold_single_xfer", xfer_q.size(), 32'd1);
`endif

    // random traffic
    for (int it = 0; it < 150; it++) begin
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        Reset = 1'b1;
        step(1);
        Reset = 1'b0;
      end else if (kind < 8) begin
        btn = 4'($urandom_range(0, 15));
      end else if (kind < 12) begin
        btn = 4'b0;
      end else begin
        b = $urandom_range(0, 3);
        btn[b] = ~btn[b];
      end
      ready = ($urandom_range(0, 2) != 0);
      step($urandom_range(1, 12));
    end
    btn = 4'b0;
    ready = 1'b1;
    step(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
